// File: rtl/fetch_pkg.sv
// Shared types and default widths for the instruction fetch stage.
package fetch_pkg;

    localparam int DEF_ADDRESS_WIDTH = 8;
    localparam int DEF_INSTR_WIDTH   = 32;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

    // True while the stage is still waiting on instruction memory.
    function automatic logic fetch_busy(input fetch_state_t s);
        return (s == REQ) || (s == WAIT);
    endfunction

endpackage

// File: rtl/fetch_stall_counter.sv
// Saturating 16-bit count of cycles the fetch stage spends stalled on memory.
module fetch_stall_counter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    output logic [15:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 16'h0000;
        end else if (stall && (count != 16'hFFFF)) begin
            count <= count + 16'h0001;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Single-outstanding instruction fetch: request -> wait for word -> hold for decode.
// Define FETCH_STALL_CNT_EN to add the stall_cycles output and its counter.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
    parameter int INSTR_WIDTH   = DEF_INSTR_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [ADDRESS_WIDTH-1:0] pc_in,
    output logic                     pc_advance,
    input  logic                     flush,
    output logic                     imem_req_valid,
    input  logic                     imem_req_ready,
    output logic [ADDRESS_WIDTH-1:0] imem_req_addr,
    input  logic                     imem_rsp_valid,
    input  logic [INSTR_WIDTH-1:0]   imem_rsp_data,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [INSTR_WIDTH-1:0]   instr_out,
    output logic [ADDRESS_WIDTH-1:0] instr_pc
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [15:0]              stall_cycles
`endif
);

    fetch_state_t             state, state_nxt;
    logic [ADDRESS_WIDTH-1:0] req_pc;
    logic                     fresh, fresh_nxt;
    logic                     drop_pending, drop_nxt;
    logic                     rsp_take;

    // While fresh, the address follows pc_in so a request can issue on the
    // entry cycle; it is frozen into req_pc once the request is presented.
    assign imem_req_addr = (fresh && rst_n) ? pc_in : req_pc;

    always_comb begin
        state_nxt      = state;
        fresh_nxt      = fresh;
        drop_nxt       = drop_pending;
        imem_req_valid = 1'b0;
        pc_advance     = 1'b0;
        rsp_take       = 1'b0;

        if (drop_pending && imem_rsp_valid) drop_nxt = 1'b0;

        unique case (state)
            REQ: begin
                imem_req_valid = rst_n && !drop_pending;
                if (imem_req_valid) fresh_nxt = 1'b0;
                if (imem_req_valid && imem_req_ready) state_nxt = WAIT;
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    rsp_take  = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (instr_ready) begin
                    pc_advance = 1'b1;
                    fresh_nxt  = 1'b1;
                    state_nxt  = REQ;
                end
            end
            default: state_nxt = REQ;
        endcase

        // A redirect abandons the fetch; a request already accepted by memory
        // leaves one response in flight that must be swallowed later.
        if (flush) begin
            pc_advance = 1'b1;
            fresh_nxt  = 1'b1;
            rsp_take   = 1'b0;
            state_nxt  = REQ;
            if ((state == WAIT && !imem_rsp_valid) ||
                (state == REQ && imem_req_valid && imem_req_ready))
                drop_nxt = 1'b1;
        end

        pc_advance = pc_advance && rst_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= REQ;
            req_pc       <= '0;
            fresh        <= 1'b1;
            drop_pending <= 1'b0;
            instr_valid  <= 1'b0;
            instr_out    <= '0;
            instr_pc     <= '0;
        end else begin
            state        <= state_nxt;
            fresh        <= fresh_nxt;
            drop_pending <= drop_nxt;
            if (state == REQ && fresh) req_pc <= pc_in;
            if (rsp_take) begin
                instr_out   <= imem_rsp_data;
                instr_pc    <= req_pc;
                instr_valid <= 1'b1;
            end else if (state == HOLD && (flush || instr_ready)) begin
                instr_valid <= 1'b0;
            end
        end
    end

`ifdef FETCH_STALL_CNT_EN
    fetch_stall_counter u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .stall (fetch_busy(state) && !imem_req_ready),
        .count (stall_cycles)
    );
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a scoreboard of expected fetched words.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  pc_in;
    logic        pc_advance;
    logic        flush;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [7:0]  imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_out;
    logic [7:0]  instr_pc;
`ifdef FETCH_STALL_CNT_EN
    logic [15:0] stall_cycles;
`endif

    typedef struct {
        logic [31:0] instr;
        logic [7:0]  pc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    logic prev_adv = 1'b0;
    logic prev_flush = 1'b0;

    always #5 clk = ~clk;

    fetch_stage #(.ADDRESS_WIDTH(8), .INSTR_WIDTH(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc_in          (pc_in),
        .pc_advance     (pc_advance),
        .flush          (flush),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_out      (instr_out),
        .instr_pc       (instr_pc)
`ifdef FETCH_STALL_CNT_EN
        ,
        .stall_cycles   (stall_cycles)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic push(input logic [31:0] w, input logic [7:0] a);
        exp_t e;
        e.instr = w;
        e.pc    = a;
        sb.push_back(e);
    endtask

    // Called on a decode handshake; the held word must be the oldest expected.
    task automatic sb_pop();
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_underflow", 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            chk("instr_valid", instr_valid, 1'b1);
            chk("instr_out", instr_out, e.instr);
            chk("instr_pc", instr_pc, e.pc);
        end
    endtask

    // Background checks: no back-to-back pc_advance without back-to-back flush,
    // and the flushed stale word never reaches decode.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("adv_pulse", pc_advance && prev_adv && !(flush && prev_flush), 1'b0);
            if (instr_valid) chk("stale_word", instr_out == 32'hDEADBEEF, 1'b0);
        end
        prev_adv   = pc_advance;
        prev_flush = flush;
    end

    initial begin
        rst_n = 1'b0; pc_in = 8'h00; flush = 1'b0; imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0; instr_ready = 1'b0;
        settle();
        chk("rst_req_valid", imem_req_valid, 1'b0);
        chk("rst_pc_adv", pc_advance, 1'b0);
        chk("rst_instr_valid", instr_valid, 1'b0);
        chk("rst_instr_out", instr_out, 32'h0);
        chk("rst_instr_pc", instr_pc, 8'h0);
        step();

        // Basic fetch, zero-wait memory
        rst_n = 1'b1;
        settle();
        chk("c0_req_valid", imem_req_valid, 1'b1);
        chk("c0_req_addr", imem_req_addr, 8'h00);
        step();
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'hF8000000;
        push(32'hF8000000, 8'h00);
        settle();
        chk("c1_req_valid", imem_req_valid, 1'b0);
        chk("c1_instr_valid", instr_valid, 1'b0);
        step();
        imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;

        // Decode back-pressure for 5 cycles
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("bp_instr_valid", instr_valid, 1'b1);
            chk("bp_instr_out", instr_out, 32'hF8000000);
            chk("bp_pc_adv", pc_advance, 1'b0);
            step();
        end
        instr_ready = 1'b1;
        settle();
        chk("hs_pc_adv", pc_advance, 1'b1);
        sb_pop();
        step();
        instr_ready = 1'b0; pc_in = 8'h04; imem_req_ready = 1'b0;
        settle();
        chk("post_pc_adv", pc_advance, 1'b0);
        chk("post_instr_valid", instr_valid, 1'b0);

        // Memory stall with pc_in moving underneath
        for (int i = 0; i < 3; i++) begin
            chk("stall_req_valid", imem_req_valid, 1'b1);
            chk("stall_req_addr", imem_req_addr, 8'h04);
            step();
            pc_in = 8'h10 + 8'(i);
            settle();
        end
        imem_req_ready = 1'b1;
        settle();
        chk("stall_end_addr", imem_req_addr, 8'h04);
`ifdef FETCH_STALL_CNT_EN
        chk("stall_cycles", stall_cycles, 16'd3);
`endif
        step();
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h12345678;
        push(32'h12345678, 8'h04);
        step();
        imem_rsp_valid = 1'b0; instr_ready = 1'b1;
        settle();
        chk("f2_pc_adv", pc_advance, 1'b1);
        sb_pop();
        step();
        instr_ready = 1'b0; pc_in = 8'h08;
        settle();
        chk("f3_req_addr", imem_req_addr, 8'h08);

        // Flush in WAIT, stale response must be swallowed
        step();
        flush = 1'b1;
        settle();
        chk("fl_wait_pc_adv", pc_advance, 1'b1);
        step();
        flush = 1'b0; pc_in = 8'h40;
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEADBEEF;
        settle();
        chk("drop_req_valid", imem_req_valid, 1'b0);
        chk("drop_pc_adv", pc_advance, 1'b0);
        step();
        imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
        settle();
        chk("drop_instr_valid", instr_valid, 1'b0);
        chk("redir_req_valid", imem_req_valid, 1'b1);
        chk("redir_req_addr", imem_req_addr, 8'h40);
        step();
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'hAABBCCDD;
        push(32'hAABBCCDD, 8'h40);
        step();
        imem_rsp_valid = 1'b0; instr_ready = 1'b1;
        settle();
        sb_pop();
        step();
        instr_ready = 1'b0; pc_in = 8'h44;
        settle();
        chk("f5_req_addr", imem_req_addr, 8'h44);

        // Flush and instr_ready together in HOLD: one pulse, word discarded
        step();
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h55667788;
        step();
        imem_rsp_valid = 1'b0; flush = 1'b1; instr_ready = 1'b1;
        settle();
        chk("fh_instr_valid", instr_valid, 1'b1);
        chk("fh_pc_adv", pc_advance, 1'b1);
        step();
        flush = 1'b0; instr_ready = 1'b0; pc_in = 8'h80;
        settle();
        chk("fh_next_pc_adv", pc_advance, 1'b0);
        chk("fh_next_instr_valid", instr_valid, 1'b0);
        chk("fh_next_addr", imem_req_addr, 8'h80);
        step();
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0BADF00D;
        step();
        imem_rsp_valid = 1'b0;
        settle();
        chk("pre_rst_instr_valid", instr_valid, 1'b1);
        chk("pre_rst_instr_out", instr_out, 32'h0BADF00D);

        // Reset while holding an instruction
        rst_n = 1'b0;
        settle();
        chk("mrst_instr_valid", instr_valid, 1'b0);
        chk("mrst_instr_out", instr_out, 32'h0);
        chk("mrst_instr_pc", instr_pc, 8'h0);
        chk("mrst_pc_adv", pc_advance, 1'b0);
        chk("mrst_req_valid", imem_req_valid, 1'b0);
        chk("mrst_req_addr", imem_req_addr, 8'h0);
        pc_in = 8'h20;
        step();
        step();
        rst_n = 1'b1;
        settle();
        chk("restart_req_valid", imem_req_valid, 1'b1);
        chk("restart_req_addr", imem_req_addr, 8'h20);
        step();
        imem_rsp_valid = 1'b1; imem_rsp_data = 32'hCAFEF00D;
        push(32'hCAFEF00D, 8'h20);
        step();
        imem_rsp_valid = 1'b0; instr_ready = 1'b1;
        settle();
        sb_pop();
        step();
        instr_ready = 1'b0;
        settle();
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
